// File: rtl/port_array_queue_pkg.sv
// Shared definitions for the port-array queue: occupancy width, packed-slice
// offsets and the per-cycle handshake outcome encoding.
package port_array_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_DEQ  = 2'b01,
      OP_ENQ  = 2'b10,
      OP_BOTH = 2'b11
   } q_op_e;

   function automatic int calc_cw(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic int slice_off(input int i, input int w);
      return i * w;
   endfunction

endpackage

// File: rtl/port_array_queue_if.sv
// Flattened val/rdy port-array bundle; master is the producer/consumer side,
// slave is the queue.
interface port_array_queue_if
   import port_array_pkg::*;
#(
   parameter int nports   = 2,
   parameter int nbits    = 32,
   parameter int nentries = 2
);
   localparam int cw = calc_cw(nentries);

   logic [nports-1:0]       enq_val;
   logic [nports-1:0]       enq_rdy;
   logic [nports*nbits-1:0] enq_msg;
   logic [nports-1:0]       deq_val;
   logic [nports-1:0]       deq_rdy;
   logic [nports*nbits-1:0] deq_msg;
   logic [nports*cw-1:0]    count;

   modport master (
      output enq_val, enq_msg, deq_rdy,
      input  enq_rdy, deq_val, deq_msg, count
   );

   modport slave (
      input  enq_val, enq_msg, deq_rdy,
      output enq_rdy, deq_val, deq_msg, count
   );

endinterface

// File: rtl/port_array_queue_chan.sv
// Single-channel circular-buffer FIFO with val/rdy on both sides; no bypass,
// so a message becomes visible the cycle after it is enqueued.
module port_array_queue_chan
   import port_array_pkg::*;
#(
   parameter int  nbits    = 32,
   parameter int  nentries = 2,
   localparam int cw       = calc_cw(nentries),
   localparam int aw       = $clog2(nentries)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_val,
   output logic             enq_rdy,
   input  logic [nbits-1:0] enq_msg,
   output logic             deq_val,
   input  logic             deq_rdy,
   output logic [nbits-1:0] deq_msg,
   output logic [cw-1:0]    count
);

   logic [nbits-1:0] mem_r [nentries];
   logic [aw-1:0]    enq_ptr_r;
   logic [aw-1:0]    deq_ptr_r;
   logic [cw-1:0]    count_r;
   logic             full_s;
   logic             empty_s;
   logic             enq_fire_s;
   logic             deq_fire_s;
   q_op_e            op_s;

   assign full_s     = (count_r == cw'(nentries));
   assign empty_s    = (count_r == {cw{1'b0}});
   assign enq_rdy    = !full_s && !reset;
   assign deq_val    = !empty_s;
   assign enq_fire_s = enq_val && enq_rdy;
   assign deq_fire_s = deq_val && deq_rdy;
   assign op_s       = q_op_e'({enq_fire_s, deq_fire_s});
   assign deq_msg    = mem_r[deq_ptr_r];
   assign count      = count_r;

   // Storage, pointers and occupancy; reset clears everything so the head reads 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < nentries; k++) begin
            mem_r[k] <= {nbits{1'b0}};
         end
         enq_ptr_r <= {aw{1'b0}};
         deq_ptr_r <= {aw{1'b0}};
         count_r   <= {cw{1'b0}};
      end else begin
         if (enq_fire_s) begin
            mem_r[enq_ptr_r] <= enq_msg;
            enq_ptr_r        <= enq_ptr_r + aw'(1);
         end
         if (deq_fire_s) begin
            deq_ptr_r <= deq_ptr_r + aw'(1);
         end
         case (op_s)
            OP_ENQ:  count_r <= count_r + cw'(1);
            OP_DEQ:  count_r <= count_r - cw'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/port_array_queue.sv
// Array of independent per-channel FIFOs between flattened val/rdy port arrays;
// channel i occupies slice i of every packed bus.
module port_array_queue
   import port_array_pkg::*;
#(
   parameter int  nports   = 2,
   parameter int  nbits    = 32,
   parameter int  nentries = 2,
   localparam int cw       = calc_cw(nentries)
) (
   input logic               clk,
   input logic               reset,
   port_array_queue_if.slave q
);

   for (genvar i = 0; i < nports; i++) begin : g_chan
      port_array_queue_chan #(
         .nbits    (nbits),
         .nentries (nentries)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .enq_val (q.enq_val[i]),
         .enq_rdy (q.enq_rdy[i]),
         .enq_msg (q.enq_msg[slice_off(i, nbits) +: nbits]),
         .deq_val (q.deq_val[i]),
         .deq_rdy (q.deq_rdy[i]),
         .deq_msg (q.deq_msg[slice_off(i, nbits) +: nbits]),
         .count   (q.count[slice_off(i, cw) +: cw])
      );
   end

endmodule

// File: tb/tb_port_array_queue.sv
// Directed bench for port_array_queue: two 32-bit channels, four entries each.
module tb_port_array_queue;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m [100];

   port_array_queue_if #(.nports(2), .nbits(32), .nentries(4)) q ();

   port_array_queue #(.nports(2), .nbits(32), .nentries(4)) dut (
      .clk   (clk),
      .reset (reset),
      .q     (q)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; q.enq_val = 2'b11; q.deq_rdy = 2'b11; q.enq_msg = 64'h1234_5678_9ABC_DEF0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++; if (q.enq_rdy !== 2'b00) begin n_bad++; $display("FAIL rst_enq_rdy: got %b expected 00", q.enq_rdy); end
         n_cmp++; if (q.deq_val !== 2'b00) begin n_bad++; $display("FAIL rst_deq_val: got %b expected 00", q.deq_val); end
         n_cmp++; if (q.count !== 6'd0) begin n_bad++; $display("FAIL rst_count: got %h expected 0", q.count); end
         n_cmp++; if (q.deq_msg !== 64'd0) begin n_bad++; $display("FAIL rst_deq_msg: got %h expected 0", q.deq_msg); end
      end
      reset = 1'b0; q.enq_val = 2'b00; q.deq_rdy = 2'b00;
      #1;
      n_cmp++; if (q.enq_rdy !== 2'b11) begin n_bad++; $display("FAIL rel_enq_rdy: got %b expected 11", q.enq_rdy); end
      n_cmp++; if (q.deq_val !== 2'b00) begin n_bad++; $display("FAIL rel_deq_val: got %b expected 00", q.deq_val); end
   endtask

   task automatic test_latency();
      q.enq_val = 2'b10; q.enq_msg = {32'hDEAD_BEEF, 32'h0000_0000};
      #1;
      n_cmp++; if (q.deq_val !== 2'b00) begin n_bad++; $display("FAIL lat_no_bypass: got %b expected 00", q.deq_val); end
      tick();
      q.enq_val = 2'b00;
      n_cmp++; if (q.deq_val !== 2'b10) begin n_bad++; $display("FAIL lat_deq_val: got %b expected 10", q.deq_val); end
      n_cmp++; if (q.deq_msg[63:32] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lat_msg1: got %h expected deadbeef", q.deq_msg[63:32]); end
      n_cmp++; if (q.count[5:3] !== 3'd1) begin n_bad++; $display("FAIL lat_count1: got %0d expected 1", q.count[5:3]); end
      n_cmp++; if (q.count[2:0] !== 3'd0) begin n_bad++; $display("FAIL lat_count0: got %0d expected 0", q.count[2:0]); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'd0) begin n_bad++; $display("FAIL lat_msg0: got %h expected 0", q.deq_msg[31:0]); end
      q.deq_rdy = 2'b10;
      tick();
      q.deq_rdy = 2'b00;
      n_cmp++; if (q.deq_val !== 2'b00) begin n_bad++; $display("FAIL lat_drain_val: got %b expected 00", q.deq_val); end
      n_cmp++; if (q.count !== 6'd0) begin n_bad++; $display("FAIL lat_drain_count: got %h expected 0", q.count); end
   endtask

   task automatic test_fill_wrap();
      q.deq_rdy = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         q.enq_val = 2'b01; q.enq_msg[31:0] = 32'(k);
         tick();
      end
      n_cmp++; if (q.count[2:0] !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d expected 4", q.count[2:0]); end
      n_cmp++; if (q.enq_rdy[0] !== 1'b0) begin n_bad++; $display("FAIL fill_enq_rdy: got %b expected 0", q.enq_rdy[0]); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'd1) begin n_bad++; $display("FAIL fill_head1: got %0d expected 1", q.deq_msg[31:0]); end
      q.enq_msg[31:0] = 32'd5;
      tick();
      n_cmp++; if (q.count[2:0] !== 3'd4) begin n_bad++; $display("FAIL full_ignore_count: got %0d expected 4", q.count[2:0]); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'd1) begin n_bad++; $display("FAIL full_ignore_head: got %0d expected 1", q.deq_msg[31:0]); end
      // full with both sides active: only the dequeue fires
      q.deq_rdy = 2'b01;
      tick();
      n_cmp++; if (q.count[2:0] !== 3'd3) begin n_bad++; $display("FAIL full_deq_count: got %0d expected 3", q.count[2:0]); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'd2) begin n_bad++; $display("FAIL drain_head2: got %0d expected 2", q.deq_msg[31:0]); end
      tick();
      n_cmp++; if (q.count[2:0] !== 3'd3) begin n_bad++; $display("FAIL drain_count_b: got %0d expected 3", q.count[2:0]); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'd3) begin n_bad++; $display("FAIL drain_head3: got %0d expected 3", q.deq_msg[31:0]); end
      q.enq_msg[31:0] = 32'd6;
      tick();
      q.enq_val = 2'b00;
      n_cmp++; if (q.deq_msg[31:0] !== 32'd4) begin n_bad++; $display("FAIL drain_head4: got %0d expected 4", q.deq_msg[31:0]); end
      tick();
      n_cmp++; if (q.deq_msg[31:0] !== 32'd5) begin n_bad++; $display("FAIL drain_head5: got %0d expected 5", q.deq_msg[31:0]); end
      n_cmp++; if (q.count[2:0] !== 3'd2) begin n_bad++; $display("FAIL drain_count_e: got %0d expected 2", q.count[2:0]); end
      tick();
      n_cmp++; if (q.deq_msg[31:0] !== 32'd6) begin n_bad++; $display("FAIL drain_head6: got %0d expected 6", q.deq_msg[31:0]); end
      tick();
      q.deq_rdy = 2'b00;
      n_cmp++; if (q.deq_val[0] !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b expected 0", q.deq_val[0]); end
      n_cmp++; if (q.count[2:0] !== 3'd0) begin n_bad++; $display("FAIL drain_count_end: got %0d expected 0", q.count[2:0]); end
   endtask

   task automatic test_simultaneous();
      q.enq_val = 2'b01; q.enq_msg[31:0] = 32'h77; q.deq_rdy = 2'b01;
      tick();
      n_cmp++; if (q.count[2:0] !== 3'd1) begin n_bad++; $display("FAIL sim_empty_count: got %0d expected 1", q.count[2:0]); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'h77) begin n_bad++; $display("FAIL sim_empty_head: got %h expected 77", q.deq_msg[31:0]); end
      q.enq_msg[31:0] = 32'h88;
      tick();
      n_cmp++; if (q.count[2:0] !== 3'd1) begin n_bad++; $display("FAIL sim_both_count: got %0d expected 1", q.count[2:0]); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'h88) begin n_bad++; $display("FAIL sim_both_head: got %h expected 88", q.deq_msg[31:0]); end
      q.enq_val = 2'b00;
      tick();
      q.deq_rdy = 2'b00;
      n_cmp++; if (q.count[2:0] !== 3'd0) begin n_bad++; $display("FAIL sim_drain_count: got %0d expected 0", q.count[2:0]); end
      n_cmp++; if (q.deq_val[0] !== 1'b0) begin n_bad++; $display("FAIL sim_drain_val: got %b expected 0", q.deq_val[0]); end
   endtask

   task automatic test_independence();
      for (int k = 0; k < 100; k++) m[k] = $urandom();
      q.deq_rdy = 2'b10; q.enq_val = 2'b11;
      for (int k = 0; k < 100; k++) begin
         q.enq_msg = {m[k], 32'(200 + k)};
         tick();
         n_cmp++; if (q.deq_msg[63:32] !== m[k]) begin n_bad++; $display("FAIL ind_head1[%0d]: got %h expected %h", k, q.deq_msg[63:32], m[k]); end
         n_cmp++; if (q.count[5:3] !== 3'd1) begin n_bad++; $display("FAIL ind_count1[%0d]: got %0d expected 1", k, q.count[5:3]); end
      end
      q.enq_val = 2'b00;
      n_cmp++; if (q.count[2:0] !== 3'd4) begin n_bad++; $display("FAIL ind_count0: got %0d expected 4", q.count[2:0]); end
      n_cmp++; if (q.enq_rdy[0] !== 1'b0) begin n_bad++; $display("FAIL ind_enq_rdy0: got %b expected 0", q.enq_rdy[0]); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'd200) begin n_bad++; $display("FAIL ind_head0: got %0d expected 200", q.deq_msg[31:0]); end
      tick();
      q.deq_rdy = 2'b00;
      n_cmp++; if (q.deq_val !== 2'b01) begin n_bad++; $display("FAIL ind_end_val: got %b expected 01", q.deq_val); end
   endtask

   task automatic test_async_reset();
      // channel 0 drops 200,201; channel 1 gains two entries
      q.deq_rdy = 2'b01; q.enq_val = 2'b10; q.enq_msg = {32'hA1, 32'd0};
      tick();
      q.enq_msg = {32'hA2, 32'd0};
      tick();
      q.deq_rdy = 2'b00; q.enq_val = 2'b00;
      n_cmp++; if (q.count !== 6'b010_010) begin n_bad++; $display("FAIL ar_pre_count: got %b expected 010010", q.count); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'd202) begin n_bad++; $display("FAIL ar_pre_head0: got %0d expected 202", q.deq_msg[31:0]); end
      n_cmp++; if (q.deq_msg[63:32] !== 32'hA1) begin n_bad++; $display("FAIL ar_pre_head1: got %h expected a1", q.deq_msg[63:32]); end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (q.deq_val !== 2'b00) begin n_bad++; $display("FAIL ar_deq_val: got %b expected 00", q.deq_val); end
      n_cmp++; if (q.count !== 6'd0) begin n_bad++; $display("FAIL ar_count: got %h expected 0", q.count); end
      n_cmp++; if (q.enq_rdy !== 2'b00) begin n_bad++; $display("FAIL ar_enq_rdy: got %b expected 00", q.enq_rdy); end
      n_cmp++; if (q.deq_msg !== 64'd0) begin n_bad++; $display("FAIL ar_deq_msg: got %h expected 0", q.deq_msg); end
      #1;
      reset = 1'b0;
      tick();
      n_cmp++; if (q.deq_val !== 2'b00) begin n_bad++; $display("FAIL ar_post_val: got %b expected 00", q.deq_val); end
      n_cmp++; if (q.count !== 6'd0) begin n_bad++; $display("FAIL ar_post_count: got %h expected 0", q.count); end
      q.enq_val = 2'b01; q.enq_msg = {32'd0, 32'h55};
      tick();
      q.enq_val = 2'b00;
      n_cmp++; if (q.deq_val !== 2'b01) begin n_bad++; $display("FAIL ar_fresh_val: got %b expected 01", q.deq_val); end
      n_cmp++; if (q.deq_msg[31:0] !== 32'h55) begin n_bad++; $display("FAIL ar_fresh_head: got %h expected 55", q.deq_msg[31:0]); end
      n_cmp++; if (q.count[2:0] !== 3'd1) begin n_bad++; $display("FAIL ar_fresh_count: got %0d expected 1", q.count[2:0]); end
   endtask

   initial begin
      q.enq_val = 2'b00;
      q.deq_rdy = 2'b00;
      q.enq_msg = 64'd0;
      test_reset();
      test_latency();
      test_fill_wrap();
      test_simultaneous();
      test_independence();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/port_array_queue.md
# port_array_queue

Parametrised successor to the flattened port-array pass-through: `nports` independent channels, each a `nentries`-deep val/rdy FIFO. Message ports are packed the same way, with channel `i` on bits `[i*nbits +: nbits]`. The block sits between producers and consumers that exchange flattened port arrays and need per-channel elasticity, with no cross-channel coupling. Each channel's behaviour is fully independent of every other channel.

## Interface
Parameters:
- `nports`, default 2: number of channels, ≥1.
- `nbits`, default 32: message width per channel, ≥1.
- `nentries`, default 2: FIFO depth per channel; a power of two, ≥2.

Ports (`cw = $clog2(nentries)+1`):
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `enq_val`  input  `nports`  bit `i` = channel `i` enqueue valid.
- `enq_rdy`  output  `nports`  bit `i` = channel `i` can accept.
- `enq_msg`  input  `nports*nbits`  packed enqueue messages.
- `deq_val`  output  `nports`  bit `i` = channel `i` has data.
- `deq_rdy`  input  `nports`  bit `i` = consumer of channel `i` accepts.
- `deq_msg`  output  `nports*nbits`  packed head-of-queue messages.
- `count`  output  `nports*cw`  packed per-channel occupancy; channel `i` on `[i*cw +: cw]`.

## Operation
- Per channel, an enqueue fires when `enq_val[i] & enq_rdy[i]`. A dequeue fires when `deq_val[i] & deq_rdy[i]`.
- `enq_rdy[i] = !full[i] & !reset`.
- `deq_val[i] = !empty[i]`.
- `deq_msg` slice `i` always shows the head entry. Its value is undefined in content but stable while `deq_val[i]=0`. After reset, storage is cleared, so it reads 0.
- Storage per channel: circular buffer with `nentries` entries, an enqueue pointer, a dequeue pointer, and a `cw`-bit count.
  - Pointers are `$clog2(nentries)` bits and wrap naturally from `nentries-1` to 0.
  - full = (count == `nentries`); empty = (count == 0).
- Count update per cycle:
  - enqueue only: +1
  - dequeue only: −1
  - both, or neither: unchanged
- Simultaneous enqueue and dequeue:
  - Allowed whenever the channel is neither full nor empty.
  - When full: `enq_rdy` is low, so only the dequeue fires. No pipe/bypass path exists.
  - When empty: `deq_val` is low, so only the enqueue fires. No bypass; the message becomes visible next cycle.
- Order is strictly FIFO per channel. There is no reordering or arbitration across channels.
- Driving `enq_val` while `enq_rdy` is low is legal; it is ignored. Dequeue has the same rule.
- Reset values, held for as long as `reset` is high:
  - `enq_rdy` = 0
  - `deq_val` = 0
  - `count` = 0
  - `deq_msg` = 0
  - all pointers = 0
- Reset asserted mid-operation discards all queued messages immediately (asynchronously). No partial transfer completes on the edge where reset is high.

## Timing
- Enqueue-to-dequeue latency: 1 cycle. A message enqueued at edge N appears with `deq_val` high after edge N.
- Throughput: 1 message/cycle/channel sustained when `nentries` ≥ 2 and the consumer is always ready.
- `enq_rdy` and `deq_val` depend only on registered state and `reset`. They have no combinational path from `enq_val` or `deq_rdy`.
- `deq_msg` is driven from registered storage through a read mux indexed by the dequeue pointer. There is no input-to-output combinational path.
- The first enqueue after reset deassertion is accepted on the first rising edge with `reset` low.

## Structure
- Shared package `port_array_pkg`:
  - localparam function for `cw` (`$clog2(nentries)+1`).
  - slice-offset helper for packed port arrays (`i*w`).
- Sub-module `port_array_queue_chan`: a single-channel FIFO with scalar val/rdy, `nbits`-wide msg, and `count`.
- The top level is a `generate` loop of `nports` instances plus packing and unpacking of the flat buses. It holds no other logic.

## Test plan
- **Reset state.** Hold reset for 3 cycles with `enq_val` all ones → `enq_rdy`=0, `deq_val`=0, `count`=0, `deq_msg`=0 throughout. The cycle after release, `enq_rdy` = all ones.
- **Single-channel latency.** `nports`=2, `nentries`=2. Enqueue 0xDEADBEEF on channel 1 only → the next cycle gives `deq_val`=2'b10, channel 1 `deq_msg`=0xDEADBEEF, channel 1 `count`=1. Channel 0 is unaffected.
- **Fill/full/drain with wrap.** `nentries`=4, `deq_rdy`=0, enqueue 1,2,3,4 → `count`=4 and `enq_rdy[0]`=0. Attempt to enqueue 5 → ignored. Then `deq_rdy`=1 while enqueuing 5,6 as slots free → dequeue order 1,2,3,4,5,6, with the pointers wrapping past 3.
- **Simultaneous enqueue/dequeue.** At `count`=1, enqueue and dequeue in the same cycle → `count` stays 1 and the next head is the newly enqueued value. When full with `deq_rdy`=1 and `enq_val`=1 → only the dequeue fires and `count` drops to 3.
- **Channel independence.** Channel 0 is stalled (`deq_rdy[0]`=0) and fills while channel 1 streams 100 random messages → channel 1 delivers every message in order at 1/cycle. Channel 0 `count` stays at `nentries`.
- **Async reset mid-stream.** Pulse reset between clock edges while both channels hold 2 entries → `deq_val` and `count` drop to 0 before the next edge. Messages queued before the pulse never appear afterward.
